// File: rtl/led_matrix_scanner.sv
// Row-scanned driver for a 16x16 red/green LED matrix fed through a 32-bit column shift chain.
// Optional macro FRAME_SNAPSHOT_EN serves each frame from a buffer copied at row 0 (tear-free).
module led_matrix_scanner #(
  parameter int unsigned DWELL = 1000
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              enable,
  input  logic [15:0][15:0] RedPixels,
  input  logic [15:0][15:0] GrnPixels,
  output logic              sdata,
  output logic              sclk,
  output logic              slatch,
  output logic [3:0]        row_sel,
  output logic              row_en,
  output logic              frame_done
);
  localparam int unsigned ROW_W   = 4;
  localparam int unsigned BIT_W   = 6;
  localparam int unsigned DWELL_W = 16;
  localparam int unsigned WORD_W  = 32;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(63);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(15);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DISPLAY} state_t;

  state_t              state, nxt_state;
  logic [ROW_W-1:0]    row_cnt, nxt_row_cnt;
  logic [BIT_W-1:0]    bit_cnt, nxt_bit_cnt;
  logic [DWELL_W-1:0]  dwell_cnt, nxt_dwell_cnt;
  logic [WORD_W-1:0]   shreg, nxt_shreg;
  logic [WORD_W-1:0]   row_word;
  logic                nxt_sdata, nxt_sclk, nxt_slatch, nxt_row_en, nxt_frame_done;
  logic [ROW_W-1:0]    nxt_row_sel;

`ifdef FRAME_SNAPSHOT_EN
  logic [15:0][15:0] red_buf, grn_buf;

  // Copy the whole frame when row 0 loads; row 0 itself is taken from the live inputs.
  always_ff @(posedge clk) begin
    if (state == LOAD && row_cnt == '0) begin
      red_buf <= RedPixels;
      grn_buf <= GrnPixels;
    end
  end

  assign row_word = (row_cnt == '0) ? {RedPixels[0], GrnPixels[0]}
                                    : {red_buf[row_cnt], grn_buf[row_cnt]};
`else
  assign row_word = {RedPixels[row_cnt], GrnPixels[row_cnt]};
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= IDLE;
      row_cnt    <= '0;
      bit_cnt    <= '0;
      dwell_cnt  <= '0;
      shreg      <= '0;
      sdata      <= 1'b0;
      sclk       <= 1'b0;
      slatch     <= 1'b0;
      row_sel    <= '0;
      row_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      row_cnt    <= nxt_row_cnt;
      bit_cnt    <= nxt_bit_cnt;
      dwell_cnt  <= nxt_dwell_cnt;
      shreg      <= nxt_shreg;
      sdata      <= nxt_sdata;
      sclk       <= nxt_sclk;
      slatch     <= nxt_slatch;
      row_sel    <= nxt_row_sel;
      row_en     <= nxt_row_en;
      frame_done <= nxt_frame_done;
    end
  end

  // Next state; outputs are decoded from the next state so they line up with it once registered.
  always_comb begin
    nxt_state     = state;
    nxt_row_cnt   = row_cnt;
    nxt_bit_cnt   = bit_cnt;
    nxt_dwell_cnt = dwell_cnt;
    nxt_shreg     = shreg;

    unique case (state)
      IDLE: begin
        if (enable) nxt_state = LOAD;
      end
      LOAD: begin
        nxt_shreg   = row_word;
        nxt_bit_cnt = '0;
        nxt_state   = SHIFT;
      end
      SHIFT: begin
        nxt_bit_cnt = bit_cnt + BIT_W'(1);
        // Advance to the next bit only after its sclk-high half.
        if (bit_cnt[0]) nxt_shreg = {shreg[WORD_W-2:0], 1'b0};
        if (bit_cnt == BIT_LAST) nxt_state = LATCH;
      end
      LATCH: begin
        nxt_dwell_cnt = '0;
        nxt_state     = DISPLAY;
      end
      DISPLAY: begin
        if (dwell_cnt == DWELL_LAST) begin
          nxt_dwell_cnt = '0;
          if (enable) begin
            nxt_row_cnt = row_cnt + ROW_W'(1);
            nxt_state   = LOAD;
          end else begin
            nxt_row_cnt = '0;
            nxt_state   = IDLE;
          end
        end else begin
          nxt_dwell_cnt = dwell_cnt + DWELL_W'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase

    nxt_sdata      = (nxt_state == SHIFT) && nxt_shreg[WORD_W-1];
    nxt_sclk       = (nxt_state == SHIFT) && nxt_bit_cnt[0];
    nxt_slatch     = (nxt_state == LATCH);
    nxt_row_en     = (nxt_state == DISPLAY);
    nxt_frame_done = (nxt_state == DISPLAY) && (nxt_dwell_cnt == DWELL_LAST) &&
                     (row_cnt == ROW_LAST);
    nxt_row_sel    = row_sel;
    if (nxt_state == IDLE)       nxt_row_sel = '0;
    else if (nxt_state == LATCH) nxt_row_sel = row_cnt;
  end

endmodule
